// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Two-master command bus plus single-port memory bus for the arbiter
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 31
);
  logic [1:0]              req;
  logic [1:0]              wr;
  logic [2*ADDR_WIDTH-1:0] addr;
  logic [2*DATA_WIDTH-1:0] wdata;
  logic [1:0]              gnt;
  logic [1:0]              done;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rdata_out;
  logic                    busy;
  logic                    mem_req;
  logic                    mem_wr;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_slv_rsp;

  modport slave (
    input  req, wr, addr, wdata, mem_rdata, mem_slv_rsp,
    output gnt, done, err, rdata_out, busy, mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req, wr, addr, wdata, mem_rdata, mem_slv_rsp,
    input  gnt, done, err, rdata_out, busy, mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter/sequencer for two masters sharing one memory
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 31,
  parameter int MEM_SIZE   = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [ADDR_WIDTH:0] c_mem_size = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [7:0]          c_timeout  = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ptr;
  logic                  r_owner;
  logic [1:0]            r_gnt;
  logic                  r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [7:0]            r_cnt;

  logic                  w_winner;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_in_range;
  logic                  w_take;
  logic                  w_load;
  logic                  w_load_err;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [7:0]            w_cnt_inc;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    w_winner = r_ptr;
    if (bus.req == 2'b01)
      w_winner = 1'b0;
    else if (bus.req == 2'b10)
      w_winner = 1'b1;
  end

  assign w_sel_addr  = w_winner ? bus.addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                : bus.addr[ADDR_WIDTH-1:0];
  assign w_sel_wdata = w_winner ? bus.wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                : bus.wdata[DATA_WIDTH-1:0];
  assign w_in_range  = ({1'b0, w_sel_addr} < c_mem_size);
  assign w_cnt_inc   = r_cnt + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_load      = 1'b0;
    w_load_err  = 1'b0;
    w_load_data = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          w_take = 1'b1;
          if (w_in_range) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_RESP;
            w_load      = 1'b1;
            w_load_err  = 1'b1;
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        if (bus.mem_slv_rsp) begin
          w_state_nxt = S_RESP;
          w_load      = 1'b1;
          w_load_data = r_mem_wr ? '0 : bus.mem_rdata;
        end else if (r_state == S_ISSUE) begin
          w_state_nxt = S_WAIT;
        end else if (w_cnt_inc == c_timeout) begin
          // Counter tracks completed WAIT cycles; give up after TIMEOUT of them.
          w_state_nxt = S_RESP;
          w_load      = 1'b1;
          w_load_err  = 1'b1;
        end
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_gnt       <= 2'b00;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_gnt <= 2'b00;
      if (w_take) begin
        r_gnt       <= w_winner ? 2'b10 : 2'b01;
        r_owner     <= w_winner;
        r_ptr       <= ~w_winner;
        r_mem_wr    <= bus.wr[w_winner];
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
      if (r_state == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_WAIT)
        r_cnt <= w_cnt_inc;
      if (w_load) begin
        r_err   <= w_load_err;
        r_rdata <= w_load_data;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.err       = r_err;
  assign bus.rdata_out = r_rdata;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.mem_req   = (r_state == S_ISSUE);
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter with a small memory model
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 31;
  localparam logic [DW-1:0] c_data_a = 31'h0ABC_DE01;
  localparam logic [DW-1:0] c_data_b = 31'h1357_2468;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MEM_SIZE  (16),
    .TIMEOUT   (15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            owner;
    logic          err;
    logic [DW-1:0] rdata;
    bit            chk_rdata;
  } exp_t;

  exp_t          exp_q[$];
  int            exp_gnt[$];
  int            di        = 0;
  int            gi        = 0;
  int            n_cmp     = 0;
  int            n_err     = 0;
  int            n_memreq  = 0;
  int            rsp_delay = 0;
  bit            no_rsp    = 1'b0;
  logic [DW-1:0] mem [16];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int owner, input logic err, input logic [DW-1:0] rdata,
                          input bit chk_rdata);
    exp_t e;
    e.owner = owner; e.err = err; e.rdata = rdata; e.chk_rdata = chk_rdata;
    exp_q.push_back(e);
  endtask

  // Scoreboard: consume expected grants and completions as the DUT produces them
  task automatic mon();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.gnt !== 2'b00) begin
        if (gi < exp_gnt.size()) begin
          check_val("gnt_order", bus.gnt, (exp_gnt[gi] == 1) ? 2'b10 : 2'b01);
          gi++;
        end else begin
          check_val("gnt_unexpected", bus.gnt, 2'b00);
        end
      end
      if (bus.done !== 2'b00) begin
        if (di < exp_q.size()) begin
          e = exp_q[di];
          di++;
          check_val("done_owner", bus.done, (e.owner == 1) ? 2'b10 : 2'b01);
          check_val("done_err", bus.err, e.err);
          if (e.chk_rdata)
            check_val("done_rdata", bus.rdata_out, e.rdata);
        end else begin
          check_val("done_unexpected", bus.done, 2'b00);
        end
      end
      if (bus.mem_req === 1'b1)
        check_val("mem_addr_range", (bus.mem_addr < 16), 1'b1);
    end
  endtask

  task automatic mem_model();
    logic [AW-1:0] a;
    logic          w;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1 && reset) begin
        n_memreq++;
        a = bus.mem_addr;
        w = bus.mem_wr;
        if (w) mem[a[3:0]] = bus.mem_wdata;
        if (!no_rsp) begin
          repeat (rsp_delay) @(negedge clk);
          bus.mem_rdata   = w ? 31'h2A5A_5A5A : mem[a[3:0]];
          bus.mem_slv_rsp = 1'b1;
          @(negedge clk);
          bus.mem_slv_rsp = 1'b0;
        end
      end
    end
  endtask

  task automatic do_cmd(input int m, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit keep);
    bit got;
    bus.wr[m] = w;
    if (m == 0) begin
      bus.addr[AW-1:0]  = a;
      bus.wdata[DW-1:0] = d;
    end else begin
      bus.addr[2*AW-1:AW]  = a;
      bus.wdata[2*DW-1:DW] = d;
    end
    bus.req[m] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.gnt[m]) got = 1'b1;
    end
    check_val($sformatf("gnt_wait_m%0d", m), got, 1'b1);
    if (!keep) bus.req[m] = 1'b0;
  endtask

  // Called in the grant cycle; n = cycles from grant to done.
  task automatic wait_done(input int m, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      check_val("busy_hold", bus.busy, 1'b1);
    end while (!bus.done[m] && n < 40);
    check_val("done_seen", bus.done[m], 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (di < exp_q.size() || gi < exp_gnt.size()); i++)
      @(negedge clk);
    check_val("drain_done", di, exp_q.size());
    check_val("drain_gnt", gi, exp_gnt.size());
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_gnt"},       bus.gnt,       2'b00);
    check_val({tag, "_done"},      bus.done,      2'b00);
    check_val({tag, "_err"},       bus.err,       1'b0);
    check_val({tag, "_rdata"},     bus.rdata_out, '0);
    check_val({tag, "_busy"},      bus.busy,      1'b0);
    check_val({tag, "_mem_req"},   bus.mem_req,   1'b0);
    check_val({tag, "_mem_wr"},    bus.mem_wr,    1'b0);
    check_val({tag, "_mem_addr"},  bus.mem_addr,  '0);
    check_val({tag, "_mem_wdata"}, bus.mem_wdata, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish within 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int mr;
    bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata = '0; bus.mem_slv_rsp = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    fork
      mon();
      mem_model();
    join_none

    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    // Master 0 write, zero-wait memory
    rsp_delay = 0;
    exp_gnt.push_back(0);
    push_exp(0, 1'b0, '0, 1'b1);
    @(negedge clk);
    do_cmd(0, 1'b1, 8'd3, 31'h1234, 1'b0);
    check_val("t1_mem_req",   bus.mem_req,   1'b1);
    check_val("t1_mem_wr",    bus.mem_wr,    1'b1);
    check_val("t1_mem_addr",  bus.mem_addr,  8'd3);
    check_val("t1_mem_wdata", bus.mem_wdata, 31'h1234);
    check_val("t1_no_done",   bus.done,      2'b00);
    @(posedge clk); #1;
    check_val("t1_done", bus.done, 2'b01);
    drain();
    check_val("t1_mem_content", mem[3], 31'h1234);

    // Master 1 read, three WAIT cycles
    rsp_delay = 3;
    exp_gnt.push_back(1);
    push_exp(1, 1'b0, 31'h1234, 1'b1);
    @(negedge clk);
    do_cmd(1, 1'b0, 8'd3, '0, 1'b0);
    wait_done(1, n);
    check_val("t2_latency", n, 5'd4);
    drain();

    // Both masters busy: grants must alternate 0,1,0,1
    rsp_delay = 1;
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    push_exp(0, 1'b0, '0, 1'b1);
    push_exp(1, 1'b0, '0, 1'b1);
    push_exp(0, 1'b0, c_data_b, 1'b1);
    push_exp(1, 1'b0, c_data_a, 1'b1);
    @(negedge clk);
    fork
      begin
        do_cmd(0, 1'b1, 8'd5, c_data_a, 1'b1);
        do_cmd(0, 1'b0, 8'd6, '0, 1'b0);
      end
      begin
        do_cmd(1, 1'b1, 8'd6, c_data_b, 1'b1);
        do_cmd(1, 1'b0, 8'd5, '0, 1'b0);
      end
    join
    drain();

    // Out-of-range address never reaches memory
    mr = n_memreq;
    exp_gnt.push_back(0);
    push_exp(0, 1'b1, '0, 1'b0);
    @(negedge clk);
    do_cmd(0, 1'b0, 8'd16, '0, 1'b0);
    check_val("t4_done_with_gnt", bus.done,    2'b01);
    check_val("t4_no_mem_req",    bus.mem_req, 1'b0);
    @(posedge clk); #1;
    check_val("t4_idle", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    check_val("t4_memreq_count", n_memreq, mr);
    drain();

    // Successful read so the timeout's zero rdata is observable
    rsp_delay = 0;
    exp_gnt.push_back(0);
    push_exp(0, 1'b0, c_data_b, 1'b1);
    @(negedge clk);
    do_cmd(0, 1'b0, 8'd6, '0, 1'b0);
    drain();

    // Timeout: memory never answers
    no_rsp = 1'b1;
    exp_gnt.push_back(1);
    push_exp(1, 1'b1, '0, 1'b1);
    @(negedge clk);
    do_cmd(1, 1'b0, 8'd7, '0, 1'b0);
    wait_done(1, n);
    check_val("t5_timeout_latency", n, 5'd16);
    @(posedge clk); #1;
    bus.mem_slv_rsp = 1'b1;
    @(posedge clk); #1;
    bus.mem_slv_rsp = 1'b0;
    check_val("t5_late_rsp_busy", bus.busy,    1'b0);
    check_val("t5_late_rsp_done", bus.done,    2'b00);
    check_val("t5_err_held",      bus.err,     1'b1);
    check_val("t5_late_rsp_req",  bus.mem_req, 1'b0);
    drain();

    // Reset in WAIT aborts silently and restores pointer to master 0
    exp_gnt.push_back(0);
    @(negedge clk);
    do_cmd(0, 1'b0, 8'd2, '0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    check_val("t6_in_wait", bus.busy, 1'b1);
    reset = 1'b0;
    #1;
    check_zero("t6_rst");
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    no_rsp = 1'b0;
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    push_exp(0, 1'b0, 31'h1234, 1'b1);
    push_exp(1, 1'b0, c_data_a, 1'b1);
    @(negedge clk);
    fork
      do_cmd(0, 1'b0, 8'd3, '0, 1'b0);
      do_cmd(1, 1'b0, 8'd5, '0, 1'b0);
    join
    drain();
    repeat (3) @(negedge clk);
    check_val("final_idle", bus.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
